// File: rtl/seg_decode_rx.sv
// Seven-segment receiver: decodes two strobed digit patterns (low then high) into a byte.
// Define SEG_DECODE_STABLE_FILTER_EN to require STABLE_CYCLES of unchanged Seg before a digit is accepted.
module seg_decode_rx #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Clear_b,
  input  logic [6:0] Seg,
  input  logic       SegStrobe,
  output logic [7:0] Byte,
  output logic       ByteValid,
  output logic       Error,
  output logic       Busy
);

  typedef enum logic [1:0] {
    S_LO,
    S_LO_CHK,
    S_HI,
    S_HI_CHK
  } state_t;

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable_cycles
    $error("seg_decode_rx: STABLE_CYCLES must be within 1..15");
  end

  state_t     state, state_nxt;
  logic [6:0] pat_q;
  logic [3:0] lo_q;
  logic       capture;
  logic       accept;
  logic       err_nxt;
  logic [3:0] pat_nib;

  // Segment inputs are active-low; compare against lit-segment masks (bit0 = a).
  function automatic logic seg_valid(input logic [6:0] seg);
    logic [6:0] lit;
    lit = ~seg;
    case (lit)
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71: seg_valid = 1'b1;
      default:                                               seg_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] seg_nibble(input logic [6:0] seg);
    logic [6:0] lit;
    lit = ~seg;
    case (lit)
      7'h06:   seg_nibble = 4'h1;
      7'h5B:   seg_nibble = 4'h2;
      7'h4F:   seg_nibble = 4'h3;
      7'h66:   seg_nibble = 4'h4;
      7'h6D:   seg_nibble = 4'h5;
      7'h7D:   seg_nibble = 4'h6;
      7'h07:   seg_nibble = 4'h7;
      7'h7F:   seg_nibble = 4'h8;
      7'h6F:   seg_nibble = 4'h9;
      7'h77:   seg_nibble = 4'hA;
      7'h7C:   seg_nibble = 4'hB;
      7'h39:   seg_nibble = 4'hC;
      7'h5E:   seg_nibble = 4'hD;
      7'h79:   seg_nibble = 4'hE;
      7'h71:   seg_nibble = 4'hF;
      default: seg_nibble = 4'h0;
    endcase
  endfunction

  assign pat_nib = seg_nibble(pat_q);
  assign Busy    = (state != S_LO);

`ifdef SEG_DECODE_STABLE_FILTER_EN
  logic [3:0] cnt_q;
  logic       in_chk;

  assign in_chk = (state == S_LO_CHK) || (state == S_HI_CHK);

  // Counts consecutive cycles in a CHK state where Seg still equals the captured pattern.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else if (!Clear_b || !in_chk || err_nxt || accept) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_LO, S_HI: begin
        if (SegStrobe) begin
          capture = 1'b1;
          if (seg_valid(Seg)) begin
            state_nxt = (state == S_LO) ? S_LO_CHK : S_HI_CHK;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_LO;
          end
        end
      end
      S_LO_CHK, S_HI_CHK: begin
`ifdef SEG_DECODE_STABLE_FILTER_EN
        if (Seg != pat_q) begin
          err_nxt   = 1'b1;
          state_nxt = S_LO;
        end else if (cnt_q == 4'(STABLE_CYCLES - 1)) begin
          accept = 1'b1;
        end
`else
        accept = 1'b1;
`endif
        if (accept) begin
          state_nxt = (state == S_LO_CHK) ? S_HI : S_LO;
        end
      end
      default: state_nxt = S_LO;
    endcase
    // Synchronous clear wins over any strobe or acceptance in the same cycle.
    if (!Clear_b) begin
      state_nxt = S_LO;
      capture   = 1'b0;
      accept    = 1'b0;
      err_nxt   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_LO;
      pat_q     <= 7'h7F;
      lo_q      <= '0;
      Byte      <= '0;
      ByteValid <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      Error     <= err_nxt;
      ByteValid <= accept && (state == S_HI_CHK);
      if (capture) begin
        pat_q <= Seg;
      end
      if (!Clear_b) begin
        lo_q <= '0;
        Byte <= '0;
      end else if (accept && (state == S_LO_CHK)) begin
        lo_q <= pat_nib;
      end else if (accept && (state == S_HI_CHK)) begin
        Byte <= {pat_nib, lo_q};
      end
    end
  end

endmodule

// File: tb/tb_seg_decode_rx.sv
// Self-checking bench for seg_decode_rx: scoreboard of expected bytes popped on each ByteValid.
// Handles both builds, with and without SEG_DECODE_STABLE_FILTER_EN.
module tb_seg_decode_rx;

  localparam int SC = 4;
`ifdef SEG_DECODE_STABLE_FILTER_EN
  localparam bit FILTER   = 1'b1;
  localparam int CHK_WAIT = SC + 2;
`else
  localparam bit FILTER   = 1'b0;
  localparam int CHK_WAIT = 2;
`endif

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Clear_b;
  logic [6:0] Seg;
  logic       SegStrobe;
  logic [7:0] Byte;
  logic       ByteValid;
  logic       Error;
  logic       Busy;

  int         tests = 0;
  int         fails = 0;
  int         bv_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;

  // Lit segments per digit, written straight from the decode table.
  string lit_str[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  seg_decode_rx #(.STABLE_CYCLES(SC)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Clear_b   (Clear_b),
    .Seg       (Seg),
    .SegStrobe (SegStrobe),
    .Byte      (Byte),
    .ByteValid (ByteValid),
    .Error     (Error),
    .Busy      (Busy)
  );

  always #5 Clock = ~Clock;

  function automatic logic [6:0] seg_from_lit(input string s);
    logic [6:0] r;
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    return seg_from_lit(lit_str[d]);
  endfunction

  // Output monitor: pops the scoreboard on each ByteValid, sampled mid-cycle.
  always @(negedge Clock) begin
    if (Error) err_cnt++;
    if (ByteValid) begin
      bv_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL byte_unexpected: Byte=%h with no expected byte queued", Byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (Byte !== e) begin
          fails++;
          $display("FAIL byte_value: got %h expected %h", Byte, e);
        end
      end
      if (Error) begin
        fails++;
        $display("FAIL bv_and_error: ByteValid and Error both high");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic strobe(input logic [6:0] s);
    Seg = s;
    SegStrobe = 1'b1;
    cyc(1);
    SegStrobe = 1'b0;
  endtask

  task automatic send_byte(input int hi, input int lo);
    strobe(seg_of(lo));
    cyc(CHK_WAIT);
    exp_q.push_back({4'(hi), 4'(lo)});
    last_byte = {4'(hi), 4'(lo)};
    strobe(seg_of(hi));
    cyc(CHK_WAIT);
  endtask

  task automatic test_reset;
    int bv0;
    Resetn = 1'b0; Clear_b = 1'b1; Seg = 7'h7F; SegStrobe = 1'b0;
    #3;
    chk("reset_byte", 32'(Byte), 32'h00);
    chk("reset_bv", 32'(ByteValid), 32'h0);
    chk("reset_err", 32'(Error), 32'h0);
    chk("reset_busy", 32'(Busy), 32'h0);
    cyc(2);
    Resetn = 1'b1;
    cyc(1);
    send_byte(1, 2);
    chk("pre_reset_byte", 32'(Byte), 32'h12);
    strobe(seg_of(7));
    cyc(CHK_WAIT);
    chk("in_s_hi_busy", 32'(Busy), 32'h1);
    #2 Resetn = 1'b0;
    #1;
    chk("async_reset_byte", 32'(Byte), 32'h00);
    chk("async_reset_busy", 32'(Busy), 32'h0);
    cyc(1);
    Resetn = 1'b1;
    last_byte = 8'h00;
    cyc(1);
    bv0 = bv_cnt;
    send_byte(5, 3);
    chk("after_reset_byte", 32'(Byte), 32'h53);
    chk("after_reset_bv_count", 32'(bv_cnt - bv0), 32'd1);
  endtask

  task automatic test_decode;
    int bv0, e0;
    bv0 = bv_cnt; e0 = err_cnt;
    strobe(seg_of(5));
    chk("lo_chk_busy", 32'(Busy), 32'h1);
    cyc(CHK_WAIT);
    exp_q.push_back(8'hA5);
    last_byte = 8'hA5;
    strobe(seg_of(10));
    cyc(CHK_WAIT);
    chk("a5_byte", 32'(Byte), 32'hA5);
    chk("a5_bv_count", 32'(bv_cnt - bv0), 32'd1);
    chk("a5_no_error", 32'(err_cnt - e0), 32'd0);
    for (int d = 0; d < 16; d += 2) send_byte(d, d + 1);
    for (int i = 0; i < 6; i++) send_byte(int'($urandom_range(15)), int'($urandom_range(15)));
    chk("decode_bv_count", 32'(bv_cnt - bv0), 32'd15);
    chk("decode_no_error", 32'(err_cnt - e0), 32'd0);
  endtask

  task automatic test_invalid;
    int e0, bv0;
    logic [6:0] bad[3];
    bad[0] = 7'h7F;
    bad[1] = seg_from_lit("a");
    bad[2] = seg_from_lit("abcde");
    for (int i = 0; i < 3; i++) begin
      e0 = err_cnt;
      strobe(bad[i]);
      chk("invalid_lo_error", 32'(Error), 32'h1);
      chk("invalid_lo_busy", 32'(Busy), 32'h0);
      cyc(1);
      chk("invalid_lo_pulse_len", 32'(Error), 32'h0);
      chk("invalid_lo_byte_hold", 32'(Byte), 32'(last_byte));
      chk("invalid_lo_err_count", 32'(err_cnt - e0), 32'd1);
    end
    bv0 = bv_cnt;
    strobe(seg_of(9));
    cyc(CHK_WAIT);
    strobe(7'h7F);
    chk("invalid_hi_error", 32'(Error), 32'h1);
    chk("invalid_hi_busy", 32'(Busy), 32'h0);
    cyc(CHK_WAIT);
    chk("invalid_hi_no_bv", 32'(bv_cnt - bv0), 32'd0);
    chk("invalid_hi_byte_hold", 32'(Byte), 32'(last_byte));
    send_byte(7, 8);
    chk("after_invalid_byte", 32'(Byte), 32'h78);
  endtask

  task automatic test_filter;
    int e0;
    e0 = err_cnt;
    strobe(seg_of(5));
    cyc(1);
    Seg = seg_of(6);
    cyc(1);
    if (FILTER) begin
      chk("filter_mismatch_error", 32'(Error), 32'h1);
      chk("filter_mismatch_busy", 32'(Busy), 32'h0);
      cyc(CHK_WAIT);
      chk("filter_byte_hold", 32'(Byte), 32'(last_byte));
      send_byte(12, 4);
      chk("filter_recover_byte", 32'(Byte), 32'hC4);
    end else begin
      chk("nofilter_no_error", 32'(err_cnt - e0), 32'd0);
      chk("nofilter_in_s_hi", 32'(Busy), 32'h1);
      exp_q.push_back(8'hA5);
      last_byte = 8'hA5;
      strobe(seg_of(10));
      cyc(CHK_WAIT);
      chk("nofilter_byte", 32'(Byte), 32'hA5);
    end
  endtask

  task automatic test_clear;
    int bv0, e0;
    strobe(seg_of(9));
    cyc(CHK_WAIT);
    bv0 = bv_cnt; e0 = err_cnt;
    Seg = seg_of(14);
    SegStrobe = 1'b1;
    Clear_b = 1'b0;
    cyc(1);
    SegStrobe = 1'b0;
    Clear_b = 1'b1;
    chk("clear_byte", 32'(Byte), 32'h00);
    chk("clear_busy", 32'(Busy), 32'h0);
    last_byte = 8'h00;
    cyc(CHK_WAIT + 2);
    chk("clear_no_bv", 32'(bv_cnt - bv0), 32'd0);
    chk("clear_no_err", 32'(err_cnt - e0), 32'd0);
    send_byte(2, 11);
    chk("after_clear_byte", 32'(Byte), 32'h2B);
  endtask

  task automatic test_extra_strobe;
    int bv0;
    strobe(seg_of(1));
    cyc(CHK_WAIT);
    bv0 = bv_cnt;
    exp_q.push_back(8'hD1);
    last_byte = 8'hD1;
    Seg = seg_of(13);
    SegStrobe = 1'b1;
    cyc(1);
    if (!FILTER) Seg = seg_of(4);
    cyc(1);
    SegStrobe = 1'b0;
    Seg = seg_of(13);
    cyc(CHK_WAIT);
    chk("extra_strobe_byte", 32'(Byte), 32'hD1);
    chk("extra_strobe_bv_count", 32'(bv_cnt - bv0), 32'd1);
    chk("extra_strobe_idle", 32'(Busy), 32'h0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_invalid();
    test_filter();
    test_clear();
    test_extra_strobe();
    cyc(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
